// File: rtl/fifo_ptr_ctrl.sv
// Pointer controller for one side of an async FIFO: the write side (MODE=0) gives the full flag, the read side (MODE=1) gives the empty flag.
// Latency: a local accept shows in flag/level 1 cycle later; a remote pointer change shows SYNC_STAGES+1 cycles later.
// Backpressure: ack_o = inc_i & ~flag_o. A request while the flag is set is dropped and sets the sticky err_o.
// Ports: clk_i/reset_n_i  local clock and async active-low reset
//        inc_i            push (MODE 0) or pop (MODE 1) request
//        remote_gray_i    other domain's Gray pointer, asynchronous to clk_i
//        ack_o            request accepted this cycle
//        addr_o           RAM address
//        ptr_bin_o/ptr_gray_o  local pointer, binary and registered Gray
//        flag_o           full or empty
//        almost_flag_o    almost-full or almost-empty
//        level_o          occupancy seen from this side
//        err_o            sticky overflow/underflow
module fifo_ptr_ctrl #(
  parameter int ADDR_SIZE   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int ALMOST_TH   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 inc_i,
  input  logic [ADDR_SIZE:0]   remote_gray_i,
  output logic                 ack_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [ADDR_SIZE:0]   ptr_bin_o,
  output logic [ADDR_SIZE:0]   ptr_gray_o,
  output logic                 flag_o,
  output logic                 almost_flag_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 err_o
);

  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH = 1 << ADDR_SIZE;
  // Inverting the two MSBs of a Gray code gives the Gray code of (value + DEPTH).
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] ALMOST_HI = PW'(DEPTH - ALMOST_TH);
  localparam logic [PW-1:0] ALMOST_LO = PW'(ALMOST_TH);
  // The read side starts out empty, so its flags reset high.
  localparam logic FLAG_RST = (MODE != 0);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rsync;
  logic [PW-1:0] rbin;

  logic [PW-1:0] bin_q,    bin_d;
  logic [PW-1:0] gray_q,   gray_d;
  logic [PW-1:0] level_q,  level_d;
  logic          flag_q,   flag_d;
  logic          almost_q, almost_d;
  logic          err_q,    err_d;
  logic          ack;

  // Plain flop chain with no logic between the stages.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= remote_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rsync = sync_q[SYNC_STAGES-1];

  always_comb begin
    // Binary bit i of a Gray value is the XOR of all Gray bits at position i and above.
    rbin = '0;
    for (int i = 0; i < PW; i++) rbin[i] = ^(rsync >> i);

    ack    = inc_i & ~flag_q;
    bin_d  = ack ? bin_q + PW'(1) : bin_q;
    gray_d = bin_d ^ (bin_d >> 1);
    err_d  = err_q | (inc_i & flag_q);

    flag_d   = FLAG_RST;
    almost_d = FLAG_RST;
    level_d  = '0;
    if (MODE == 0) begin
      level_d  = bin_d - rbin;
      flag_d   = (gray_d == (rsync ^ FULL_MASK));
      almost_d = (level_d >= ALMOST_HI);
    end else begin
      level_d  = rbin - bin_d;
      flag_d   = (gray_d == rsync);
      almost_d = (level_d <= ALMOST_LO);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= FLAG_RST;
      almost_q <= FLAG_RST;
      err_q    <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      err_q    <= err_d;
    end
  end

  assign ack_o         = ack;
  assign addr_o        = bin_q[ADDR_SIZE-1:0];
  assign ptr_bin_o     = bin_q;
  assign ptr_gray_o    = gray_q;
  assign flag_o        = flag_q;
  assign almost_flag_o = almost_q;
  assign level_o       = level_q;
  assign err_o         = err_q;

endmodule
